pc88_ioctl_loader: RTL and testbench

PC88_IOCTL_LOADER -- requirements
Module: pc88_ioctl_loader

---
 rtl/pc88_ldr_pkg.sv | 17 +
 rtl/pc88_ioctl_loader_if.sv | 40 ++++
 rtl/pc88_ldr_fifo.sv | 61 ++++++
 rtl/pc88_ioctl_loader.sv | 158 +++++++++++++++
 tb/tb_pc88_ioctl_loader.sv | 362 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pc88_ldr_pkg.sv
// Shared types and default constants for the PC-88 ioctl loader.
package pc88_ldr_pkg;

  localparam int DEF_FIFO_DEPTH  = 4;
  localparam int DEF_ADDR_W      = 19;
  localparam int DEF_ACK_TIMEOUT = 65535;

  // Loader sequencing states; also exported on the debug port.
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOAD     = 3'd1,
    ST_WAIT_ACK = 3'd2,
    ST_DRAIN    = 3'd3,
    ST_DONE     = 3'd4
  } ldr_state_t;

endpackage

// File: rtl/pc88_ioctl_loader_if.sv
// Bundle of the HPS download port and the core memory-write port.
//
// Handshakes:
//   HPS side : a byte is offered for exactly one clk_sys cycle with
//              ioctl_wr=1. ioctl_wait=1 asks the HPS to hold off further
//              bytes; a byte offered while the buffer is full is lost and
//              flagged on ldr_err.
//   Core side: ldr_wr rises with ldr_adr/ldr_wdat valid and stays high,
//              with address and data frozen, until the core raises
//              ldr_ack (a 0->1 transition completes the write).
interface pc88_ioctl_loader_if
  import pc88_ldr_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
);
  logic              ioctl_download;
  logic              ioctl_wr;
  logic [24:0]       ioctl_addr;
  logic [7:0]        ioctl_dout;
  logic              ioctl_wait;
  logic [ADDR_W-1:0] ldr_adr;
  logic [7:0]        ldr_wdat;
  logic              ldr_oe;
  logic              ldr_wr;
  logic              ldr_ack;
  logic              ldr_done;
  logic              ldr_err;

  // Environment side: HPS plus the core that acknowledges writes.
  modport master (
    output ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, ldr_ack,
    input  ioctl_wait, ldr_adr, ldr_wdat, ldr_oe, ldr_wr, ldr_done, ldr_err
  );

  // Loader side.
  modport slave (
    input  ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, ldr_ack,
    output ioctl_wait, ldr_adr, ldr_wdat, ldr_oe, ldr_wr, ldr_done, ldr_err
  );
endinterface

// File: rtl/pc88_ldr_fifo.sv
// Small synchronous FIFO holding {addr, data} pairs between the HPS
// strobe and the core write handshake. Pushes while full and pops while
// empty are ignored; a pop only sees entries present before the edge.
module pc88_ldr_fifo
  import pc88_ldr_pkg::*;
#(
  parameter int DEPTH = DEF_FIFO_DEPTH,
  parameter int W     = DEF_ADDR_W + 8
) (
  input  logic                     clk_sys,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     push,
  input  logic [W-1:0]             din,
  input  logic                     pop,
  output logic [W-1:0]             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] cnt;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (cnt == CW'(DEPTH));
  assign empty   = (cnt == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = mem[rd_ptr];
  assign count   = cnt;

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk_sys) begin
    if (push_ok && !clear) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      cnt <= cnt + CW'(push_ok) - CW'(pop_ok);
    end
  end
endmodule

// File: rtl/pc88_ioctl_loader.sv
// Bridges the MiSTer HPS ioctl download stream into level-held,
// acknowledged memory writes for the PC-88 core, with a small byte
// buffer, back-pressure, ack timeout and sticky done/error flags.
module pc88_ioctl_loader
  import pc88_ldr_pkg::*;
#(
  parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int ACK_TIMEOUT = DEF_ACK_TIMEOUT
) (
  input  logic               clk_sys,
  input  logic               reset,
  pc88_ioctl_loader_if.slave bus,
  output ldr_state_t         dbg_state
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int TW = $clog2(ACK_TIMEOUT + 1);

  ldr_state_t        state;
  logic              dl_q;
  logic              ack_q;
  logic [TW-1:0]     ack_timer;

  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_clear;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CW-1:0]     fifo_count;
  logic [CW-1:0]     count_nxt;
  logic [ADDR_W+7:0] fifo_din;
  logic [ADDR_W+7:0] fifo_dout;

  logic              dl_rise;
  logic              ack_rise;
  logic              ack_expired;
  logic              accepting;
  logic              restart;
  logic              push_ok;
  logic              drain_nxt;
  logic              wait_nxt;

  assign dbg_state   = state;
  assign dl_rise     = bus.ioctl_download && !dl_q;
  assign ack_rise    = bus.ldr_ack && !ack_q;
  assign accepting   = (state == ST_LOAD) || (state == ST_WAIT_ACK) || (state == ST_DRAIN);
  assign fifo_push   = bus.ioctl_wr && accepting;
  assign push_ok     = fifo_push && !fifo_full;
  assign fifo_pop    = ((state == ST_LOAD) || (state == ST_DRAIN)) && !fifo_empty;
  assign restart     = dl_rise && ((state == ST_IDLE) || (state == ST_DONE));
  assign fifo_clear  = restart;
  assign fifo_din    = {bus.ioctl_addr[ADDR_W-1:0], bus.ioctl_dout};
  assign ack_expired = (state == ST_WAIT_ACK) && (ack_timer == TW'(ACK_TIMEOUT - 1));

  // High address bits of the HPS byte address are deliberately dropped.
  if (ADDR_W < 25) begin : g_addr_hi
    logic unused_addr_hi;
    assign unused_addr_hi = ^bus.ioctl_addr[24:ADDR_W];
  end

  pc88_ldr_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (ADDR_W + 8)
  ) u_fifo (
    .clk_sys (clk_sys),
    .reset   (reset),
    .clear   (fifo_clear),
    .push    (fifo_push),
    .din     (fifo_din),
    .pop     (fifo_pop),
    .dout    (fifo_dout),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // Post-edge occupancy and DRAIN entry, so the registered ioctl_wait
  // reflects the buffer as it stands after each edge.
  always_comb begin
    count_nxt = fifo_count + CW'(push_ok) - CW'(fifo_pop);
    if (restart) count_nxt = '0;
    drain_nxt = 1'b0;
    case (state)
      ST_LOAD:     drain_nxt = !fifo_pop && !bus.ioctl_download;
      ST_WAIT_ACK: drain_nxt = (ack_rise || ack_expired) && !bus.ioctl_download;
      default:     drain_nxt = 1'b0;
    endcase
    wait_nxt = (count_nxt >= CW'(FIFO_DEPTH - 1)) || drain_nxt;
  end

  // Loader sequencer with registered outputs.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state          <= ST_IDLE;
      dl_q           <= 1'b1;  // a download already active at release is not an edge
      ack_q          <= 1'b0;
      ack_timer      <= '0;
      bus.ioctl_wait <= 1'b0;
      bus.ldr_adr    <= '0;
      bus.ldr_wdat   <= '0;
      bus.ldr_oe     <= 1'b0;
      bus.ldr_wr     <= 1'b0;
      bus.ldr_done   <= 1'b0;
      bus.ldr_err    <= 1'b0;
    end else begin
      dl_q           <= bus.ioctl_download;
      ack_q          <= bus.ldr_ack;
      bus.ioctl_wait <= wait_nxt;
      if (fifo_push && fifo_full) bus.ldr_err <= 1'b1;

      case (state)
        ST_IDLE: begin
          if (dl_rise) begin
            state      <= ST_LOAD;
            bus.ldr_oe <= 1'b1;
          end
        end

        ST_LOAD, ST_DRAIN: begin
          if (fifo_pop) begin
            bus.ldr_adr  <= fifo_dout[ADDR_W+7:8];
            bus.ldr_wdat <= fifo_dout[7:0];
            bus.ldr_wr   <= 1'b1;
            ack_timer    <= '0;
            state        <= ST_WAIT_ACK;
          end else if (state == ST_DRAIN) begin
            state        <= ST_DONE;
            bus.ldr_oe   <= 1'b0;
            bus.ldr_done <= 1'b1;
          end else if (!bus.ioctl_download) begin
            state <= ST_DRAIN;
          end
        end

        ST_WAIT_ACK: begin
          if (ack_rise || ack_expired) begin
            bus.ldr_wr <= 1'b0;
            if (!ack_rise) bus.ldr_err <= 1'b1;
            state <= bus.ioctl_download ? ST_LOAD : ST_DRAIN;
          end else begin
            ack_timer <= ack_timer + TW'(1);
          end
        end

        ST_DONE: begin
          if (dl_rise) begin
            state        <= ST_LOAD;
            bus.ldr_oe   <= 1'b1;
            bus.ldr_done <= 1'b0;
            bus.ldr_err  <= 1'b0;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pc88_ioctl_loader.sv
// Directed and randomized bench for the ioctl loader: drives HPS bytes,
// emulates the acknowledging core, and compares delivered writes and
// flags against expectations derived from the loader's behaviour rules.
module tb_pc88_ioctl_loader;
  import pc88_ldr_pkg::*;

  localparam int DEPTH  = 4;
  localparam int AW     = 19;
  localparam int ACK_TO = 16;

  logic       clk_sys;
  logic       reset;
  ldr_state_t dbg_state;

  pc88_ioctl_loader_if #(.ADDR_W(AW)) bus ();

  pc88_ioctl_loader #(
    .FIFO_DEPTH  (DEPTH),
    .ADDR_W      (AW),
    .ACK_TIMEOUT (ACK_TO)
  ) dut (
    .clk_sys   (clk_sys),
    .reset     (reset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // Clock and watchdog
  initial begin
    clk_sys = 1'b0;
    forever #5 clk_sys = ~clk_sys;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not reach its end, observed running expected finished");
    $fatal(1, "watchdog expired");
  end

  // Scoreboard state
  int          n_checks;
  int          n_errors;
  logic [26:0] exp_q[$];
  logic [26:0] got_q[$];
  int          pushed;
  bit          ack_en;
  int          ack_delay;
  int          hi_cnt;
  logic        prev_wr;
  logic [26:0] held;
  bit          wait_seen;
  int          first_wait_occ;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #2;
  endtask

  // Core emulation: acknowledges each write after ack_delay cycles of
  // ldr_wr high, records issued writes and checks they stay frozen.
  initial begin
    bus.ldr_ack = 1'b0;
    hi_cnt      = 0;
    prev_wr     = 1'b0;
    held        = '0;
    forever begin
      @(posedge clk_sys);
      #1;
      if (reset) begin
        bus.ldr_ack = 1'b0;
        hi_cnt      = 0;
        prev_wr     = 1'b0;
      end else begin
        if (bus.ldr_ack) begin
          bus.ldr_ack = 1'b0;
        end else if (bus.ldr_wr) begin
          hi_cnt++;
          if (ack_en && hi_cnt >= ack_delay) begin
            bus.ldr_ack = 1'b1;
            hi_cnt      = 0;
          end
        end else begin
          hi_cnt = 0;
        end
        if (bus.ldr_wr && !prev_wr) begin
          held = {bus.ldr_adr, bus.ldr_wdat};
          got_q.push_back(held);
        end else if (bus.ldr_wr && prev_wr) begin
          chk("hold_stable", {5'b0, bus.ldr_adr, bus.ldr_wdat}, {5'b0, held});
        end
        prev_wr = bus.ldr_wr;
      end
    end
  end

  // Driver tasks
  task automatic put(input logic [24:0] a, input logic [7:0] d);
    bus.ioctl_wr   = 1'b1;
    bus.ioctl_addr = a;
    bus.ioctl_dout = d;
    tick();
    bus.ioctl_wr   = 1'b0;
  endtask

  task automatic put_exp(input logic [24:0] a, input logic [7:0] d);
    put(a, d);
    exp_q.push_back({a[AW-1:0], d});
    pushed++;
  endtask

  task automatic clear_sb();
    got_q.delete();
    exp_q.delete();
    pushed = 0;
  endtask

  task automatic wait_wr_low(input string tag);
    int n = 0;
    while (bus.ldr_wr && n < 200) begin
      tick();
      n++;
    end
    chk(tag, bus.ldr_wr, 1'b0);
  endtask

  task automatic finish_dl(input string tag);
    int n = 0;
    bus.ioctl_download = 1'b0;
    while (!bus.ldr_done && n < 500) begin
      tick();
      n++;
    end
    chk({tag, "_done"}, bus.ldr_done, 1'b1);
    chk({tag, "_oe_off"}, bus.ldr_oe, 1'b0);
    chk({tag, "_wr_off"}, bus.ldr_wr, 1'b0);
  endtask

  task automatic compare_stream(input string tag);
    chk({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      chk(tag, {5'b0, got_q[i]}, {5'b0, exp_q[i]});
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_wait"}, bus.ioctl_wait, 1'b0);
    chk({tag, "_adr"}, 32'(bus.ldr_adr), 32'h0);
    chk({tag, "_wdat"}, 32'(bus.ldr_wdat), 32'h0);
    chk({tag, "_oe"}, bus.ldr_oe, 1'b0);
    chk({tag, "_wr"}, bus.ldr_wr, 1'b0);
    chk({tag, "_done"}, bus.ldr_done, 1'b0);
    chk({tag, "_err"}, bus.ldr_err, 1'b0);
    chk({tag, "_state"}, 32'(dbg_state), 32'(ST_IDLE));
  endtask

  // Sends n random bytes honouring ioctl_wait; the buffer occupancy is
  // bytes accepted minus writes issued, and ioctl_wait must be high
  // exactly when that reaches DEPTH-1.
  task automatic run_stream(input int n, input bit gaps);
    int          sent  = 0;
    int          guard = 0;
    int          occ;
    logic [24:0] a;
    logic [7:0]  d;
    while (sent < n && guard < 3000) begin
      guard++;
      occ = pushed - got_q.size();
      chk("ioctl_wait_level", bus.ioctl_wait, (occ >= DEPTH - 1));
      if (bus.ioctl_wait && !wait_seen) begin
        wait_seen      = 1'b1;
        first_wait_occ = occ;
      end
      if (!bus.ioctl_wait && (!gaps || $urandom_range(0, 2) != 0)) begin
        a = 25'($urandom);
        d = 8'($urandom);
        put_exp(a, d);
        sent++;
      end else begin
        tick();
      end
    end
    chk("stream_sent", sent, n);
  endtask

  // Directed sequence
  initial begin
    n_checks           = 0;
    n_errors           = 0;
    ack_en             = 1'b0;
    ack_delay          = 3;
    pushed             = 0;
    wait_seen          = 1'b0;
    first_wait_occ     = -1;
    reset              = 1'b1;
    bus.ioctl_download = 1'b1;
    bus.ioctl_wr       = 1'b0;
    bus.ioctl_addr     = '0;
    bus.ioctl_dout     = '0;
    repeat (3) tick();
    check_all_zero("reset");

    // Download already high at release: no edge, stay idle.
    reset = 1'b0;
    repeat (3) tick();
    chk("no_edge_state", 32'(dbg_state), 32'(ST_IDLE));
    chk("no_edge_oe", bus.ldr_oe, 1'b0);
    put(25'h00020, 8'h11);  // ignored in IDLE
    bus.ioctl_download = 1'b0;
    tick();

    // Single byte with latency check.
    clear_sb();
    ack_en    = 1'b1;
    ack_delay = 3;
    bus.ioctl_download = 1'b1;
    tick();
    chk("single_state_load", 32'(dbg_state), 32'(ST_LOAD));
    chk("single_oe", bus.ldr_oe, 1'b1);
    put_exp(25'h00010, 8'hA5);
    chk("single_wr_edge_n", bus.ldr_wr, 1'b0);
    tick();
    chk("single_wr_edge_n1", bus.ldr_wr, 1'b1);
    chk("single_adr", 32'(bus.ldr_adr), 32'h00010);
    chk("single_wdat", 32'(bus.ldr_wdat), 32'hA5);
    wait_wr_low("single_ack");
    finish_dl("single");
    chk("single_err", bus.ldr_err, 1'b0);
    compare_stream("single_data");

    // Back-pressure: 8 bytes, slow core.
    clear_sb();
    ack_delay      = 10;
    wait_seen      = 1'b0;
    first_wait_occ = -1;
    bus.ioctl_download = 1'b1;
    tick();
    chk("bp_done_cleared", bus.ldr_done, 1'b0);
    run_stream(8, 1'b0);
    chk("bp_wait_seen", 32'(wait_seen), 32'd1);
    chk("bp_wait_at_count", first_wait_occ, 3);
    finish_dl("bp");
    chk("bp_err", bus.ldr_err, 1'b0);
    compare_stream("bp_order");

    // Overflow: one write held by a silent core, then 5 more ignoring
    // ioctl_wait; four fit the buffer and the fifth is lost.
    clear_sb();
    ack_en = 1'b0;
    bus.ioctl_download = 1'b1;
    tick();
    put_exp(25'h00100, 8'h01);
    put_exp(25'h00101, 8'h02);
    put_exp(25'h00102, 8'h03);
    put_exp(25'h00103, 8'h04);
    put_exp(25'h00104, 8'h05);
    chk("ovf_wait_full", bus.ioctl_wait, 1'b1);
    chk("ovf_err_before", bus.ldr_err, 1'b0);
    put(25'h00105, 8'h06);
    chk("ovf_err_after", bus.ldr_err, 1'b1);
    ack_en    = 1'b1;
    ack_delay = 2;
    finish_dl("ovf");
    chk("ovf_err_sticky", bus.ldr_err, 1'b1);
    compare_stream("ovf_data");

    // Timeout: core never answers the first write.
    clear_sb();
    ack_en = 1'b0;
    bus.ioctl_download = 1'b1;
    tick();
    chk("to_err_cleared", bus.ldr_err, 1'b0);
    put_exp(25'h00200, 8'h3C);
    put_exp(25'h00201, 8'hC3);
    begin
      int n = 0;
      while (bus.ldr_wr && n < 100) begin
        n++;
        tick();
      end
      chk("to_wr_cycles", n, ACK_TO);
    end
    chk("to_err", bus.ldr_err, 1'b1);
    chk("to_wr_dropped", bus.ldr_wr, 1'b0);
    tick();
    chk("to_next_wr", bus.ldr_wr, 1'b1);
    chk("to_next_adr", 32'(bus.ldr_adr), 32'h00201);
    ack_en    = 1'b1;
    ack_delay = 2;
    finish_dl("to");
    compare_stream("to_data");

    // Randomized stream with random gaps and core latency.
    clear_sb();
    ack_delay = $urandom_range(1, 8);
    bus.ioctl_download = 1'b1;
    tick();
    chk("rnd_err_cleared", bus.ldr_err, 1'b0);
    run_stream(12, 1'b1);
    finish_dl("rnd");
    chk("rnd_err", bus.ldr_err, 1'b0);
    compare_stream("rnd_data");

    // Bytes in DONE are ignored; reload writes the top address.
    put(25'h00300, 8'h77);
    repeat (3) tick();
    chk("done_ignore_wr", bus.ldr_wr, 1'b0);
    chk("done_hold", bus.ldr_done, 1'b1);
    clear_sb();
    ack_delay = 3;
    bus.ioctl_download = 1'b1;
    tick();
    chk("reload_done_clr", bus.ldr_done, 1'b0);
    chk("reload_oe", bus.ldr_oe, 1'b1);
    put_exp(25'h1F7FFFF, 8'h5A);
    tick();
    chk("reload_wr", bus.ldr_wr, 1'b1);
    chk("reload_adr", 32'(bus.ldr_adr), 32'h7FFFF);
    chk("reload_wdat", 32'(bus.ldr_wdat), 32'h5A);
    finish_dl("reload");
    compare_stream("reload_data");

    // Reset while a write is pending.
    clear_sb();
    ack_en = 1'b0;
    bus.ioctl_download = 1'b1;
    tick();
    put(25'h00400, 8'hEE);
    tick();
    chk("rst_pending_wr", bus.ldr_wr, 1'b1);
    #1;
    reset = 1'b1;
    #1;
    check_all_zero("rst_async");
    repeat (2) tick();
    reset = 1'b0;
    repeat (2) tick();
    chk("rst_release_idle", 32'(dbg_state), 32'(ST_IDLE));
    bus.ioctl_download = 1'b0;
    tick();
    clear_sb();
    ack_en    = 1'b1;
    ack_delay = $urandom_range(1, 6);
    bus.ioctl_download = 1'b1;
    tick();
    put_exp(25'h00500, 8'($urandom));
    put_exp(25'h00501, 8'($urandom));
    finish_dl("rst_reload");
    chk("rst_reload_err", bus.ldr_err, 1'b0);
    compare_stream("rst_reload_data");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
